keypad_scanner: RTL and testbench

Scans a 4×4 matrix keypad by strobing one column low at a time and reading the four row lines. Debounces the reading and emits a one-cycle `key_valid` pulse with a 4-bit key code per clean press. It is the input side of the calculator, complementing the multiplexed seven-segment output driver. It feeds the operand/operator entry logic.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/keypad_scanner_sync2.sv | 26 ++
 rtl/keypad_scanner.sv | 182 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key-code table for the 4x4 matrix keypad scanner.
// Codes follow the calculator's operand/operator encoding.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } frame_cls_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Index is row*4+col
  function automatic logic [3:0] key_map(input logic [3:0] k);
    logic [3:0] code;
    case (k)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'h0;
      4'd14:   code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer; flops reset high to match idle pulled-up lines.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobe, frame snapshot, debounce FSM.
// Emits one key_valid pulse per clean single-key press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DIV_BITS        = 17,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [DIV_BITS-1:0] r_div;
  logic [1:0]          r_col;
  logic [15:0]         r_snap;
  logic [3:0]          w_row_n;
  logic                w_tick;
  logic                w_fend;
  logic [15:0]         w_frame;
  logic [4:0]          w_ones;
  logic [3:0]          w_idx;
  frame_cls_t          w_cls;

  state_t              r_state;
  state_t              w_state_nx;
  logic [3:0]          r_cand;
  logic [3:0]          w_cand_nx;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nx;
  logic                w_accept;
  logic                w_release;
  logic [3:0]          r_code;
  logic                r_valid;
  logic                r_held;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (w_row_n)
  );

  assign w_tick = &r_div;
  assign w_fend = w_tick && (r_col == 2'd3);
  assign col_n  = ~(4'b0001 << r_col);

  always_comb begin
    w_frame = r_snap;
    for (int r = 0; r < 4; r++) begin
      w_frame[{2'(r), r_col}] = ~w_row_n[r];
    end
  end

  always_comb begin
    w_ones = '0;
    w_idx  = '0;
    for (int k = 0; k < 16; k++) begin
      if (w_frame[k]) begin
        w_ones = w_ones + 5'd1;
        w_idx  = 4'(k);
      end
    end
    if (w_ones == 5'd0)      w_cls = CLS_NONE;
    else if (w_ones == 5'd1) w_cls = CLS_SINGLE;
    else                     w_cls = CLS_MULTI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_col  <= '0;
      r_snap <= '0;
    end else begin
      r_div <= r_div + 1'b1;
      if (w_tick) begin
        r_col  <= r_col + 2'd1;
        r_snap <= w_fend ? 16'h0000 : w_frame;
      end
    end
  end

  // Debounce FSM only moves at frame end
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    w_release  = 1'b0;
    if (w_fend) begin
      unique case (r_state)
        IDLE: begin
          if (w_cls == CLS_SINGLE) begin
            w_cand_nx = w_idx;
            w_cnt_nx  = CNT_ONE;
            if (CNT_MAX == CNT_ONE) begin
              w_state_nx = HELD;
              w_accept   = 1'b1;
            end else begin
              w_state_nx = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (w_cls == CLS_SINGLE && w_idx == r_cand) begin
            if (r_cnt >= CNT_MAX - CNT_ONE) begin
              w_cnt_nx   = CNT_MAX;
              w_state_nx = HELD;
              w_accept   = 1'b1;
            end else begin
              w_cnt_nx = r_cnt + CNT_ONE;
            end
          end else if (w_cls == CLS_SINGLE) begin
            w_cand_nx = w_idx;
            w_cnt_nx  = CNT_ONE;
          end else begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
          end
        end
        HELD: begin
          if (w_cls == CLS_NONE) begin
            if (CNT_MAX == CNT_ONE) begin
              w_state_nx = IDLE;
              w_cnt_nx   = '0;
              w_release  = 1'b1;
            end else begin
              w_state_nx = RELEASE;
              w_cnt_nx   = CNT_ONE;
            end
          end
        end
        RELEASE: begin
          if (w_cls != CLS_NONE) begin
            w_state_nx = HELD;
          end else if (r_cnt >= CNT_MAX - CNT_ONE) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
            w_release  = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cand  <= w_cand_nx;
      r_cnt   <= w_cnt_nx;
      r_valid <= w_accept;
      if (w_accept) begin
        r_code <= key_map(w_idx);
        r_held <= 1'b1;
      end else if (w_release) begin
        r_held <= 1'b0;
      end
    end
  end

  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-level bench for keypad_scanner: directed table plus random
// key sequences checked against a press/release reference model.
module tb_keypad_scanner;

  localparam int DB = 3;
  localparam int FRAME = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] keys;
    int          pulses;
    logic [3:0]  code;
    logic        held;
  } vec_t;

  vec_t vecs[$];

  logic [3:0] ref_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  // reference model state
  int         m_run;
  int         m_last;
  int         m_none;
  logic       m_held;
  logic [3:0] m_code;

  keypad_scanner #(.DIV_BITS(4), .DEBOUNCE_FRAMES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (col_n[c] == 1'b0 && keys[r*4+c]) row_n[r] = 1'b0;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: time limit expired, checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Starts 4 cycles into a frame; returns 4 cycles into the next one
  task automatic run_frame(input logic [15:0] k, input int ep,
                           input logic [3:0] ec, input logic eh,
                           input string tag);
    int p;
    logic [3:0] ecol;
    p = 0;
    keys = k;
    for (int i = 0; i < FRAME; i++) begin
      if (i % 16 == 0) begin
        ecol = ~(4'b0001 << (i / 16));
        chk({tag, " col_n"}, int'(col_n), int'(ecol));
      end
      @(negedge clk);
      if (key_valid) p++;
    end
    chk({tag, " pulses"}, p, ep);
    chk({tag, " key_code"}, int'(key_code), int'(ec));
    chk({tag, " key_held"}, int'(key_held), int'(eh));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset col_n", int'(col_n), 4'b1110);
    chk("reset key_code", int'(key_code), 0);
    chk("reset key_valid", int'(key_valid), 0);
    chk("reset key_held", int'(key_held), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  function automatic int model_step(input logic [15:0] k);
    int ones, idx, pulse;
    ones = 0;
    idx = 0;
    pulse = 0;
    for (int i = 0; i < 16; i++)
      if (k[i]) begin
        ones++;
        idx = i;
      end
    if (!m_held) begin
      if (ones == 1) begin
        m_run = (m_run > 0 && idx == m_last) ? m_run + 1 : 1;
        m_last = idx;
        if (m_run == DB) begin
          pulse = 1;
          m_held = 1'b1;
          m_code = ref_map[idx];
          m_none = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (ones == 0) begin
      m_none++;
      if (m_none == DB) begin
        m_held = 1'b0;
        m_run = 0;
      end
    end else begin
      m_none = 0;
    end
    return pulse;
  endfunction

  function automatic void add(input logic [15:0] k, input int p,
                              input logic [3:0] c, input logic h);
    vec_t v;
    v.keys = k;
    v.pulses = p;
    v.code = c;
    v.held = h;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] last_k;
    logic [15:0] nk;
    int ep, sel, a, b;

    // "5" held five frames, then released
    for (int i = 0; i < 5; i++)
      add(16'h0020, (i == 2) ? 1 : 0, (i >= 2) ? 4'h5 : 4'h0, i >= 2);
    add(16'h0000, 0, 4'h5, 1'b1);
    add(16'h0000, 0, 4'h5, 1'b1);
    add(16'h0000, 0, 4'h5, 1'b0);
    // "#" bouncing, then steady
    for (int i = 0; i < 6; i++)
      add((i % 2 == 0) ? 16'h4000 : 16'h0000, 0, 4'h5, 1'b0);
    add(16'h4000, 0, 4'h5, 1'b0);
    add(16'h4000, 0, 4'h5, 1'b0);
    add(16'h4000, 1, 4'hF, 1'b1);
    add(16'h4000, 0, 4'hF, 1'b1);
    add(16'h0000, 0, 4'hF, 1'b1);
    add(16'h0000, 0, 4'hF, 1'b1);
    add(16'h0000, 0, 4'hF, 1'b0);
    // "1" and "9" together
    for (int i = 0; i < 6; i++) add(16'h0401, 0, 4'hF, 1'b0);
    add(16'h0000, 0, 4'hF, 1'b0);
    // "A", then roll over to "D"
    add(16'h0008, 0, 4'hF, 1'b0);
    add(16'h0008, 0, 4'hF, 1'b0);
    add(16'h0008, 1, 4'hA, 1'b1);
    add(16'h8008, 0, 4'hA, 1'b1);
    for (int i = 0; i < 5; i++) add(16'h8000, 0, 4'hA, 1'b1);
    add(16'h0000, 0, 4'hA, 1'b1);
    add(16'h0000, 0, 4'hA, 1'b1);
    add(16'h0000, 0, 4'hA, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    chk("in-reset col_n", int'(col_n), 4'b1110);
    chk("in-reset key_held", int'(key_held), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    foreach (vecs[i])
      run_frame(vecs[i].keys, vecs[i].pulses, vecs[i].code,
                vecs[i].held, $sformatf("vec%0d", i));

    // Reset in the middle of debouncing "0"
    run_frame(16'h2000, 0, 4'hA, 1'b0, "pre-rst f1");
    run_frame(16'h2000, 0, 4'hA, 1'b0, "pre-rst f2");
    repeat (20) @(negedge clk);
    do_reset();
    run_frame(16'h2000, 0, 4'h0, 1'b0, "post-rst f1");
    run_frame(16'h2000, 0, 4'h0, 1'b0, "post-rst f2");
    run_frame(16'h2000, 1, 4'h0, 1'b1, "post-rst f3");
    run_frame(16'h0000, 0, 4'h0, 1'b1, "post-rst r1");
    run_frame(16'h0000, 0, 4'h0, 1'b1, "post-rst r2");
    run_frame(16'h0000, 0, 4'h0, 1'b0, "post-rst r3");

    // Random key sequences against the reference model
    do_reset();
    m_run = 0;
    m_last = 0;
    m_none = 0;
    m_held = 1'b0;
    m_code = 4'h0;
    last_k = '0;
    for (int f = 0; f < 48; f++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        nk = last_k;
      end else if (sel <= 6) begin
        nk = '0;
      end else if (sel <= 8) begin
        nk = 16'h0001 << $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        nk = (16'h0001 << a) | (16'h0001 << b);
      end
      last_k = nk;
      ep = model_step(nk);
      run_frame(nk, ep, m_code, m_held, $sformatf("rnd%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
